next_level_arbiter: RTL and testbench
=====================================

Name: next_level_arbiter

Overview:
N-channel arbiter that merges the next-level (miss/writeback) request ports of several caches onto one shared memory port. It generalises the fixed pair of data/instruction next-level interfaces to NUM_CHANNELS channels with fair round-robin arbitration. It also keeps per-channel grant statistics for the monitors. It sits between the cache instances and the memory model/tracedriver slave side.

Parameters:
NUM_CHANNELS, 2, number of requesting cache channels (2..16)
DATAWIDTH, 32, data bus width
ADDRESSWIDTH, 32, address bus width
COUNTWIDTH, 16, width of each per-channel saturating grant counter

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
ch_req  input  NUM_CHANNELS  per-channel request; held until that channel's ch_ack
ch_we  input  NUM_CHANNELS  per-channel write enable (1 = write, 0 = read)
ch_addr  input  NUM_CHANNELS*ADDRESSWIDTH  per-channel address, channel i at slice i
ch_wdata  input  NUM_CHANNELS*DATAWIDTH  per-channel write data
ch_ack  output  NUM_CHANNELS  one-hot, one-cycle completion pulse
ch_rdata  output  DATAWIDTH  read data, shared, valid while ch_ack is nonzero
mem_req  output  1  memory request, held until mem_ack
mem_we  output  1  memory write enable
mem_addr  output  ADDRESSWIDTH  memory address
mem_wdata  output  DATAWIDTH  memory write data
mem_ack  input  1  memory completion; mem_rdata valid in the same cycle
mem_rdata  input  DATAWIDTH  memory read data
stats_clear  input  1  synchronous clear of all grant counters
grant_count  output  NUM_CHANNELS*COUNTWIDTH  per-channel grant counters

Behaviour:
- Reset (asynchronous) drives all outputs to 0: mem_req, mem_we, mem_addr, mem_wdata, ch_ack, ch_rdata, and grant_count.
- Reset also sets state to IDLE, the round-robin pointer to 0, and the latched grant index to 0.
- Reset mid-transaction abandons the transaction. mem_req drops immediately and no ch_ack is issued.
- FSM states are IDLE, BUSY and DONE.
- IDLE: if any ch_req bit is set, grant the first requesting channel searching from rr_ptr upward, with wrap-around modulo NUM_CHANNELS.
- On a grant, latch the channel's we/addr/wdata into the mem_* registers and go to BUSY. mem_req=1 from the next cycle.
- BUSY: mem_req and the latched mem_* outputs are held stable. When mem_ack=1, register mem_rdata into ch_rdata and go to DONE.
- DONE: ch_ack[g]=1 for exactly this cycle and mem_req=0. Set rr_ptr to (g+1) mod NUM_CHANNELS and go to IDLE.
- Channel contract: ch_req[g] must be low in the cycle after ch_ack. Inputs of a requesting channel are stable until its ack.
- Latency with memory ack in the same cycle as mem_req: request sampled at edge 0 -> mem_req high in cycle 1 -> ch_ack in cycle 2 -> next grant sampled in cycle 3. Minimum 3 cycles per transaction.
- One transaction is outstanding at a time. Requests from other channels simply wait; they are never dropped.
- ch_rdata holds its last value outside DONE. On a write, ch_rdata is undefined-but-stable (it holds mem_rdata as sampled).
- mem_ack outside BUSY is ignored.
- Fairness: with all channels requesting continuously, grants rotate 0,1,...,N-1,0. No channel waits more than N-1 transactions.
- grant_count[i] increments by 1 on each grant to channel i and saturates at 2^COUNTWIDTH-1 (it does not wrap).
- stats_clear in the same cycle as a grant: the clear wins, so the count becomes 0.

Decomposition:
- Shared package cachepkg gets:
  - the state enum arb_state_t {IDLE, BUSY, DONE};
  - a function rr_select(req, ptr) returning {found, index};
  - a localparam for the channel-index width, $clog2(NUM_CHANNELS) with a minimum of 1.
- Sub-module sat_counter (WIDTH param; inc, clr, count), instantiated NUM_CHANNELS times via generate.
- The arbitration FSM stays in next_level_arbiter.

Test Plan:
- Single read, NUM_CHANNELS=2: ch_req=01, ch_addr[0]=0x1000, mem_ack after 3 cycles with mem_rdata=0xDEADBEEF -> mem_addr=0x1000 and mem_we=0 while mem_req is high; ch_ack=01 for one cycle; ch_rdata=0xDEADBEEF; grant_count[0]=1.
- Round-robin, NUM_CHANNELS=4: all four channels request continuously with an immediate-ack memory -> grant order 0,1,2,3,0,1. ch_ack spacing is exactly 3 cycles.
- Write pass-through: ch2 write, addr 0x0BEEFA55, wdata 0x12345678 -> mem_we=1 and mem_wdata=0x12345678 held stable until mem_ack. No other ch_ack is asserted.
- Reset mid-BUSY: assert reset while mem_req=1 -> mem_req=0 immediately with no ch_ack. After release, the pending channel is re-granted from rr_ptr=0.
- Saturation/clear, COUNTWIDTH=2: five grants to ch1 -> grant_count[1]=3. stats_clear coincident with a sixth grant -> 0.
- Idle noise: mem_ack pulses while in IDLE with no requests -> no state change and all outputs remain 0.

Source files
------------

// File: rtl/cachepkg.sv
`default_nettype none
// ============================================================================
//  Module      : cachepkg
//  Description : Shared types and helpers for the next-level arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package cachepkg;

    localparam int c_max_channels = 16;
    localparam int c_max_idx_w    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                   found;
        logic [c_max_idx_w-1:0] index;
    } rr_sel_t;

    // Channel-index width: $clog2(n), never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set request at or after ptr, wrapping modulo n.
    function automatic rr_sel_t rr_select(
        input logic [c_max_channels-1:0] req,
        input logic [c_max_idx_w-1:0]    ptr,
        input int                        n
    );
        rr_sel_t sel;
        int      idx;
        sel = '0;
        for (int k = 0; k < c_max_channels; k++) begin
            idx = (int'(ptr) + k) % n;
            if ((k < n) && !sel.found && req[idx[c_max_idx_w-1:0]]) begin
                sel.found = 1'b1;
                sel.index = idx[c_max_idx_w-1:0];
            end
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones; clear beats increment.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_max = {WIDTH{1'b1}};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != c_max)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/next_level_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : next_level_arbiter
//  Description : Round-robin merge of N cache next-level ports onto one
//                memory port, with per-channel saturating grant counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module next_level_arbiter
    import cachepkg::*;
#(
    parameter int NUM_CHANNELS = 2,
    parameter int DATAWIDTH    = 32,
    parameter int ADDRESSWIDTH = 32,
    parameter int COUNTWIDTH   = 16
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_CHANNELS-1:0]            ch_req,
    input  logic [NUM_CHANNELS-1:0]            ch_we,
    input  logic [NUM_CHANNELS*ADDRESSWIDTH-1:0] ch_addr,
    input  logic [NUM_CHANNELS*DATAWIDTH-1:0]  ch_wdata,
    output logic [NUM_CHANNELS-1:0]            ch_ack,
    output logic [DATAWIDTH-1:0]               ch_rdata,
    output logic                               mem_req,
    output logic                               mem_we,
    output logic [ADDRESSWIDTH-1:0]            mem_addr,
    output logic [DATAWIDTH-1:0]               mem_wdata,
    input  logic                               mem_ack,
    input  logic [DATAWIDTH-1:0]               mem_rdata,
    input  logic                               stats_clear,
    output logic [NUM_CHANNELS*COUNTWIDTH-1:0] grant_count
);

    localparam int c_idx_w = idx_width(NUM_CHANNELS);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_CHANNELS - 1);

    arb_state_t                 r_state;
    logic [c_idx_w-1:0]         r_rr_ptr;
    logic [c_idx_w-1:0]         r_grant;

    logic [c_max_channels-1:0]  w_req_ext;
    logic [c_max_idx_w-1:0]     w_ptr_ext;
    rr_sel_t                    w_sel;
    logic [c_idx_w-1:0]         w_sel_idx;
    logic                       w_grant;

    logic [ADDRESSWIDTH-1:0]    w_addr_arr  [NUM_CHANNELS];
    logic [DATAWIDTH-1:0]       w_wdata_arr [NUM_CHANNELS];

    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_unpack
            assign w_addr_arr[gi]  = ch_addr[gi*ADDRESSWIDTH +: ADDRESSWIDTH];
            assign w_wdata_arr[gi] = ch_wdata[gi*DATAWIDTH +: DATAWIDTH];
        end
    endgenerate

    always_comb begin
        w_req_ext                    = '0;
        w_req_ext[NUM_CHANNELS-1:0]  = ch_req;
        w_ptr_ext                    = '0;
        w_ptr_ext[c_idx_w-1:0]       = r_rr_ptr;
        w_sel                        = rr_select(w_req_ext, w_ptr_ext, NUM_CHANNELS);
        w_sel_idx                    = w_sel.index[c_idx_w-1:0];
        w_grant                      = (r_state == IDLE) && w_sel.found;
    end

    // One transaction in flight; the mem_* request fields are captured at
    // grant time so the channel may change its inputs right after its ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_rr_ptr  <= '0;
            r_grant   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ch_ack    <= '0;
            ch_rdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    ch_ack <= '0;
                    if (w_grant) begin
                        r_grant   <= w_sel_idx;
                        mem_we    <= ch_we[w_sel_idx];
                        mem_addr  <= w_addr_arr[w_sel_idx];
                        mem_wdata <= w_wdata_arr[w_sel_idx];
                        mem_req   <= 1'b1;
                        r_state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        ch_rdata <= mem_rdata;
                        mem_req  <= 1'b0;
                        ch_ack   <= NUM_CHANNELS'(1) << r_grant;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    ch_ack   <= '0;
                    r_rr_ptr <= (r_grant == c_last_idx) ? '0 : r_grant + c_idx_w'(1);
                    r_state  <= IDLE;
                end
                default: begin
                    ch_ack  <= '0;
                    mem_req <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_cnt
            sat_counter #(
                .WIDTH (COUNTWIDTH)
            ) u_cnt (
                .clock (clock),
                .reset (reset),
                .inc   (w_grant && (w_sel.index == c_max_idx_w'(gi))),
                .clr   (stats_clear),
                .count (grant_count[gi*COUNTWIDTH +: COUNTWIDTH])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_next_level_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_next_level_arbiter
//  Description : Self-checking bench for next_level_arbiter (4 channels,
//                2-bit grant counters).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_next_level_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int CW = 2;

    logic            clock;
    logic            reset;
    logic [N-1:0]    ch_req;
    logic [N-1:0]    ch_we;
    logic [N*AW-1:0] ch_addr;
    logic [N*DW-1:0] ch_wdata;
    logic [N-1:0]    ch_ack;
    logic [DW-1:0]   ch_rdata;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_ack;
    logic [DW-1:0]   mem_rdata;
    logic            stats_clear;
    logic [N*CW-1:0] grant_count;

    next_level_arbiter #(
        .NUM_CHANNELS (N),
        .DATAWIDTH    (DW),
        .ADDRESSWIDTH (AW),
        .COUNTWIDTH   (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .ch_req      (ch_req),
        .ch_we       (ch_we),
        .ch_addr     (ch_addr),
        .ch_wdata    (ch_wdata),
        .ch_ack      (ch_ack),
        .ch_rdata    (ch_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .stats_clear (stats_clear),
        .grant_count (grant_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  we;
        logic        ack;
        logic [31:0] rd;
        logic        clr;
        logic        exp_req;
        logic [3:0]  exp_ack;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_gc;
    } vec_t;

    vec_t tbl [10];

    int n_err;
    int n_chk;
    int cycle;

    // Reference-model state (transaction level)
    int          m_phase;
    int          m_cur;
    int          m_ptr;
    int          m_cnt [N];
    logic [31:0] m_rdata;
    logic [31:0] m_addr [N];
    logic [31:0] m_wdata [N];
    int          cool [N];
    int          delay;
    logic [N-1:0] req_d;
    logic        ack_d;
    logic        clr_d;
    logic [31:0] rd_d;
    bit          grant;
    bit          draining;
    logic [7:0]  exp_gc;
    logic [3:0]  exp_ack;
    int          order [$];
    int          times [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cycle++;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        ch_req      = '0;
        ch_we       = '0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        stats_clear = 1'b0;
        step();
        check("reset_mem_req",   mem_req,     0);
        check("reset_mem_we",    mem_we,      0);
        check("reset_mem_addr",  mem_addr,    0);
        check("reset_mem_wdata", mem_wdata,   0);
        check("reset_ch_ack",    ch_ack,      0);
        check("reset_ch_rdata",  ch_rdata,    0);
        check("reset_gc",        grant_count, 0);
        reset = 1'b0;
    endtask

    // Expected winner: first requester at or after ptr, wrapping
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic txn1(input int ch, input bit clr, input logic [7:0] gc, input string tag);
        logic [3:0] e;
        e       = '0;
        e[ch]   = 1'b1;
        ch_req  = e;
        ch_we   = '0;
        stats_clear = clr;
        step();
        stats_clear = 1'b0;
        check({tag, "_req"}, mem_req, 1);
        check({tag, "_gc"}, grant_count, gc);
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
        step();
        mem_ack = 1'b0;
        ch_req  = '0;
        check({tag, "_ack"}, ch_ack, e);
        step();
        step();
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;
        cycle = 0;
        ch_addr  = '0;
        ch_wdata = '0;

        // ---------------- table: idle noise, single read, write pass-through
        tbl[0] = '{4'h0, 4'h0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 4'h0, 32'h0,      1'b0, 32'h0,        32'h0,        8'h00};
        tbl[1] = '{4'h1, 4'h0, 1'b0, 32'h0,        1'b0, 1'b1, 4'h0, 32'h1000,   1'b0, 32'hAAAA0000, 32'h0,        8'h01};
        tbl[2] = '{4'h1, 4'h0, 1'b0, 32'h0,        1'b0, 1'b1, 4'h0, 32'h1000,   1'b0, 32'hAAAA0000, 32'h0,        8'h01};
        tbl[3] = '{4'h1, 4'h0, 1'b0, 32'h0,        1'b0, 1'b1, 4'h0, 32'h1000,   1'b0, 32'hAAAA0000, 32'h0,        8'h01};
        tbl[4] = '{4'h1, 4'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 4'h1, 32'h1000,   1'b0, 32'hAAAA0000, 32'hDEADBEEF, 8'h01};
        tbl[5] = '{4'h0, 4'h0, 1'b1, 32'h11111111, 1'b0, 1'b0, 4'h0, 32'h1000,   1'b0, 32'hAAAA0000, 32'hDEADBEEF, 8'h01};
        tbl[6] = '{4'h4, 4'h4, 1'b0, 32'h0,        1'b0, 1'b1, 4'h0, 32'h0BEEFA55, 1'b1, 32'h12345678, 32'hDEADBEEF, 8'h11};
        tbl[7] = '{4'h4, 4'h4, 1'b0, 32'h0,        1'b0, 1'b1, 4'h0, 32'h0BEEFA55, 1'b1, 32'h12345678, 32'hDEADBEEF, 8'h11};
        tbl[8] = '{4'h4, 4'h4, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 4'h4, 32'h0BEEFA55, 1'b1, 32'h12345678, 32'hCAFEF00D, 8'h11};
        tbl[9] = '{4'h0, 4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 32'h0BEEFA55, 1'b1, 32'h12345678, 32'hCAFEF00D, 8'h11};

        do_reset();
        ch_addr[31:0]   = 32'h00001000;
        ch_wdata[31:0]  = 32'hAAAA0000;
        ch_addr[95:64]  = 32'h0BEEFA55;
        ch_wdata[95:64] = 32'h12345678;
        for (int r = 0; r < 10; r++) begin
            ch_req      = tbl[r].req;
            ch_we       = tbl[r].we;
            mem_ack     = tbl[r].ack;
            mem_rdata   = tbl[r].rd;
            stats_clear = tbl[r].clr;
            step();
            check($sformatf("tbl%0d_mem_req", r),   mem_req,     tbl[r].exp_req);
            check($sformatf("tbl%0d_ch_ack", r),    ch_ack,      tbl[r].exp_ack);
            check($sformatf("tbl%0d_mem_addr", r),  mem_addr,    tbl[r].exp_addr);
            check($sformatf("tbl%0d_mem_we", r),    mem_we,      tbl[r].exp_we);
            check($sformatf("tbl%0d_mem_wdata", r), mem_wdata,   tbl[r].exp_wdata);
            check($sformatf("tbl%0d_ch_rdata", r),  ch_rdata,    tbl[r].exp_rdata);
            check($sformatf("tbl%0d_gc", r),        grant_count, tbl[r].exp_gc);
        end

        // ---------------- round robin with an immediate-ack memory
        do_reset();
        for (int i = 0; i < N; i++) begin
            ch_addr[i*32 +: 32] = 32'(i * 256);
            cool[i] = 0;
        end
        ch_req = 4'hF;
        for (int c = 0; c < 60 && order.size() < 6; c++) begin
            step();
            mem_ack = mem_req;
            for (int g = 0; g < N; g++) begin
                if (ch_ack[g]) begin
                    order.push_back(g);
                    times.push_back(cycle);
                    cool[g] = 2;
                end
            end
            for (int g = 0; g < N; g++) begin
                if (cool[g] > 0) begin
                    cool[g]--;
                    ch_req[g] = 1'b0;
                end else begin
                    ch_req[g] = 1'b1;
                end
            end
        end
        check("rr_grant_total", order.size(), 6);
        for (int k = 0; k < order.size(); k++) begin
            check($sformatf("rr_order%0d", k), order[k], k % N);
            if (k > 0) check($sformatf("rr_spacing%0d", k), times[k] - times[k-1], 3);
        end
        check("rr_gc", grant_count, 8'h5A);
        ch_req  = '0;
        mem_ack = 1'b0;
        step();
        step();
        step();

        // ---------------- saturation and clear-wins-over-grant
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            txn1(1, 1'b0, 8'(((k < 3) ? k : 3) << 2), $sformatf("sat%0d", k));
        end
        txn1(1, 1'b1, 8'h00, "sat_clear");

        // ---------------- reset in BUSY (rr pointer is 2 here)
        ch_addr[127:96] = 32'h33330000;
        ch_addr[63:32]  = 32'h11110000;
        ch_req = 4'b1000;
        step();
        check("c_busy_req",  mem_req,  1);
        check("c_busy_addr", mem_addr, 32'h33330000);
        #3;
        reset = 1'b1;
        #1;
        check("c_rst_mem_req", mem_req,     0);
        check("c_rst_ch_ack",  ch_ack,      0);
        check("c_rst_gc",      grant_count, 0);
        @(posedge clock);
        #1;
        cycle++;
        check("c_rst_hold_req", mem_req, 0);
        check("c_rst_hold_ack", ch_ack,  0);
        ch_req = 4'b1010;
        reset  = 1'b0;
        step();
        check("c_ptr0_req",  mem_req,  1);
        check("c_ptr0_addr", mem_addr, 32'h11110000);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("c_ptr0_ack", ch_ack, 4'b0010);
        ch_req = 4'b1000;
        step();
        step();
        check("c_regrant_req",  mem_req,  1);
        check("c_regrant_addr", mem_addr, 32'h33330000);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("c_regrant_ack", ch_ack, 4'b1000);
        ch_req = '0;
        step();
        step();

        // ---------------- randomized traffic against the reference model
        do_reset();
        m_phase = 0;
        m_cur   = 0;
        m_ptr   = 0;
        m_rdata = '0;
        delay   = 0;
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            cool[i]  = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            draining = (cyc >= 2880);
            req_d = ch_req;
            ack_d = mem_ack;
            clr_d = stats_clear;
            rd_d  = mem_rdata;
            step();

            grant = 1'b0;
            case (m_phase)
                0: begin
                    if (req_d != '0) begin
                        m_cur   = pick(req_d, m_ptr);
                        m_phase = 1;
                        grant   = 1'b1;
                    end
                end
                1: begin
                    if (ack_d) begin
                        m_rdata = rd_d;
                        m_phase = 2;
                    end
                end
                default: begin
                    m_ptr   = (m_cur + 1) % N;
                    m_phase = 0;
                end
            endcase
            for (int i = 0; i < N; i++) begin
                if (clr_d) m_cnt[i] = 0;
                else if (grant && (i == m_cur) && (m_cnt[i] < 3)) m_cnt[i]++;
                exp_gc[i*2 +: 2] = 2'(m_cnt[i]);
            end
            exp_ack = '0;
            if (m_phase == 2) exp_ack[m_cur] = 1'b1;

            check("rnd_mem_req",  mem_req,     (m_phase == 1));
            check("rnd_ch_ack",   ch_ack,      exp_ack);
            check("rnd_ch_rdata", ch_rdata,    m_rdata);
            check("rnd_gc",       grant_count, exp_gc);
            if (m_phase == 1) begin
                check("rnd_mem_addr",  mem_addr,  m_addr[m_cur]);
                check("rnd_mem_wdata", mem_wdata, m_wdata[m_cur]);
                check("rnd_mem_we",    mem_we,    ch_we[m_cur]);
            end

            if (m_phase == 2) begin
                ch_req[m_cur] = 1'b0;
                cool[m_cur]   = 2;
            end
            for (int i = 0; i < N; i++) begin
                if (cool[i] > 0) begin
                    cool[i]--;
                end else if (!ch_req[i] && !draining && ($urandom_range(0, 2) == 0)) begin
                    ch_req[i]  = 1'b1;
                    ch_we[i]   = 1'($urandom_range(0, 1));
                    m_addr[i]  = $urandom;
                    m_wdata[i] = $urandom;
                    ch_addr[i*32 +: 32]  = m_addr[i];
                    ch_wdata[i*32 +: 32] = m_wdata[i];
                end
            end
            if (m_phase == 1) begin
                if (grant) delay = $urandom_range(0, 3);
                if (delay == 0) begin
                    mem_ack = 1'b1;
                end else begin
                    delay--;
                    mem_ack = 1'b0;
                end
            end else begin
                mem_ack = ($urandom_range(0, 3) == 0);
            end
            mem_rdata   = $urandom;
            stats_clear = ($urandom_range(0, 15) == 0);
        end
        check("rnd_all_served", ch_req, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
